// File: rtl/clk_pkg.sv
// Shared definitions for the slow-clock monitor: FSM encoding and default tuning constants.
package clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    localparam int DEF_EXPECT_HALF = 51;
    localparam int DEF_TOL         = 2;
    localparam int DEF_TIMEOUT     = 1000;
    localparam int DEF_LOCK_COUNT  = 4;

    // True when m lies inside the closed window [lo, hi].
    function automatic logic in_window(
        input logic [31:0] m,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (m >= lo) && (m <= hi);
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchroniser chain for an asynchronous slow clock plus rise/fall detection.
// SYNC_STAGES must be in 2..4. rise/fall are combinational from the last
// synchroniser flop and its delayed copy; the consumer registers them.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clk_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;

    // Shift clk_in through the synchroniser and keep one delayed copy of its output.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            s_d_r  <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], clk_in};
            s_d_r  <= sync_r[SYNC_STAGES-1];
        end
    end

    assign s    = sync_r[SYNC_STAGES-1];
    assign rise = s & ~s_d_r;
    assign fall = ~s & s_d_r;

endmodule

// File: rtl/clk_monitor.sv
// Slow-clock monitor: turns an asynchronous slow clock into fast-domain edge
// strobes, measures each half-period and tracks lock / loss / error status.
module clk_monitor
    import clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int EXPECT_HALF = DEF_EXPECT_HALF,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             lost,
    output logic [7:0]       err_cnt
);

    localparam int                GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [GOOD_W-1:0] LOCK_C    = GOOD_W'(LOCK_COUNT);

    logic              s_s;
    logic              rise_s;
    logic              fall_s;
    logic              edge_s;
    logic              good_meas_s;
    logic              meas_s;
    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [GOOD_W-1:0] good_r;
    logic [GOOD_W-1:0] good_next_s;
    logic [7:0]        err_next_s;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock (clock),
        .rst_n (rst_n),
        .clk_in(clk_in),
        .s     (s_s),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign edge_s      = rise_s | fall_s;
    assign good_meas_s = in_window(32'(cnt_r),
                                   32'(EXPECT_HALF - TOL),
                                   32'(EXPECT_HALF + TOL));

    // Next-state, good-run and error-count decisions for the tracking FSM.
    always_comb begin
        next_state_s = state_r;
        good_next_s  = good_r;
        meas_s       = 1'b0;
        err_next_s   = err_cnt;
        case (state_r)
            ST_IDLE: begin
                if (edge_s) begin
                    next_state_s = ST_ACQUIRE;
                    good_next_s  = '0;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACQUIRE: begin
                if (edge_s) begin
                    meas_s = 1'b1;
                    if (good_meas_s) begin
                        if (good_r >= (LOCK_C - GOOD_W'(1))) begin
                            next_state_s = ST_LOCKED;
                            good_next_s  = LOCK_C;
                        end else begin
                            good_next_s  = good_r + GOOD_W'(1);
                        end
                    end else begin
                        good_next_s = '0;
                    end
                end else if (cnt_r >= TIMEOUT_C) begin
                    next_state_s = ST_LOST;
                    good_next_s  = '0;
                end else begin
                    next_state_s = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (edge_s) begin
                    meas_s = 1'b1;
                    if (good_meas_s) begin
                        next_state_s = ST_LOCKED;
                    end else begin
                        next_state_s = ST_ACQUIRE;
                        good_next_s  = '0;
                        if (err_cnt != 8'hFF) begin
                            err_next_s = err_cnt + 8'd1;
                        end else begin
                            err_next_s = err_cnt;
                        end
                    end
                end else if (cnt_r >= TIMEOUT_C) begin
                    next_state_s = ST_LOST;
                    good_next_s  = '0;
                end else begin
                    next_state_s = ST_LOCKED;
                end
            end
            ST_LOST: begin
                // The saturated count spans the dropout, so the recovering edge is not measured.
                good_next_s = '0;
                if (edge_s) begin
                    next_state_s = ST_ACQUIRE;
                end else begin
                    next_state_s = ST_LOST;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                good_next_s  = '0;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            good_r       <= '0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
            err_cnt      <= 8'd0;
        end else begin
            state_r <= next_state_s;
            good_r  <= good_next_s;
            if (edge_s) begin
                cnt_r <= CNT_W'(1);
            end else if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // Qualifying with s keeps the two strobes mutually exclusive by construction.
            rise_pulse   <= rise_s & s_s;
            fall_pulse   <= fall_s & ~s_s;
            period_valid <= meas_s;
            if (meas_s) begin
                half_period <= cnt_r;
            end else begin
                half_period <= half_period;
            end
            locked  <= (next_state_s == ST_LOCKED);
            lost    <= (next_state_s == ST_LOST);
            err_cnt <= err_next_s;
        end
    end

endmodule

// File: tb/tb_clk_monitor.sv
// Directed self-checking bench for clk_monitor (default parameters).
module tb_clk_monitor;

    logic        clock  = 1'b0;
    logic        rst_n  = 1'b0;
    logic        clk_in = 1'b0;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [15:0] half_period;
    logic        period_valid;
    logic        locked;
    logic        lost;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int pv_cnt = 0;
    int last_hp = 0;
    int pulse_cnt = 0;
    int both_cnt = 0;
    int rst_bad = 0;
    int exp_pulses = 0;
    int pv_base = 0;

    clk_monitor dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .clk_in      (clk_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .half_period (half_period),
        .period_valid(period_valid),
        .locked      (locked),
        .lost        (lost),
        .err_cnt     (err_cnt)
    );

    always #5 clock = ~clock;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (period_valid) begin
            pv_cnt  = pv_cnt + 1;
            last_hp = int'(half_period);
        end
        if (rise_pulse | fall_pulse) pulse_cnt = pulse_cnt + 1;
        if (rise_pulse & fall_pulse) both_cnt = both_cnt + 1;
        if (!rst_n && (rise_pulse || fall_pulse || period_valid || locked || lost ||
                       half_period != 16'd0 || err_cnt != 8'd0))
            rst_bad = rst_bad + 1;
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp = n_cmp + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Toggle now (just after a rising edge) and let detection complete.
    task automatic tog_now();
        clk_in     = ~clk_in;
        exp_pulses = exp_pulses + 1;
        cyc(4);
    endtask

    // Toggle n fast cycles after the previous toggle.
    task automatic tog_after(input int n);
        cyc(n - 4);
        tog_now();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while clk_in toggles
        rst_n  = 1'b0;
        clk_in = 1'b0;
        repeat (6) begin
            cyc(3);
            clk_in = ~clk_in;
        end
        cyc(3);
        check_val("rst_outputs_quiet", rst_bad, 0);
        check_val("rst_pulses", pulse_cnt, 0);
        check_val("rst_locked", int'(locked), 0);
        check_val("rst_lost", int'(lost), 0);
        check_val("rst_half_period", int'(half_period), 0);
        check_val("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        cyc(5);
        check_val("idle_locked", int'(locked), 0);
        check_val("idle_lost", int'(lost), 0);
        check_val("idle_no_pulse", pulse_cnt, 0);

        // First rise: strobe appears on the third fast edge after the change
        clk_in     = 1'b1;
        exp_pulses = exp_pulses + 1;
        @(posedge clock); @(negedge clock);
        check_val("lat_cycle1", int'(rise_pulse), 0);
        @(posedge clock); @(negedge clock);
        check_val("lat_cycle2", int'(rise_pulse), 0);
        @(posedge clock); @(negedge clock);
        check_val("lat_cycle3", int'(rise_pulse), 1);
        @(posedge clock); #1;
        check_val("idle_edge_no_meas", pv_cnt, 0);

        // Nominal 51-cycle half-periods
        for (int i = 0; i < 3; i++) begin
            tog_after(51);
            check_val("nom_half_period", last_hp, 51);
        end
        check_val("nom_not_locked_3", int'(locked), 0);
        tog_after(51);
        check_val("nom_locked_4", int'(locked), 1);
        check_val("nom_pv_count", pv_cnt, 4);
        check_val("nom_err_cnt", int'(err_cnt), 0);

        // Tolerance window edges
        tog_after(49);
        check_val("tol49_hp", last_hp, 49);
        check_val("tol49_locked", int'(locked), 1);
        tog_after(53);
        check_val("tol53_hp", last_hp, 53);
        check_val("tol53_locked", int'(locked), 1);
        tog_after(54);
        check_val("tol54_hp", last_hp, 54);
        check_val("tol54_err", int'(err_cnt), 1);
        check_val("tol54_locked", int'(locked), 0);
        for (int i = 0; i < 3; i++) tog_after(51);
        check_val("relock_3_not_yet", int'(locked), 0);
        tog_after(51);
        check_val("relock_4", int'(locked), 1);

        // Timeout: detection was 3 edges after the toggle, we are 4 edges after it
        cyc(998);
        check_val("timeout_minus1_lost", int'(lost), 0);
        cyc(1);
        check_val("timeout_lost", int'(lost), 1);
        check_val("timeout_locked", int'(locked), 0);
        pv_base = pv_cnt;
        tog_now();
        check_val("lost_exit_lost", int'(lost), 0);
        check_val("lost_exit_no_meas", pv_cnt, pv_base);
        check_val("lost_exit_locked", int'(locked), 0);
        for (int i = 0; i < 3; i++) tog_after(51);
        check_val("post_lost_3", int'(locked), 0);
        tog_after(51);
        check_val("post_lost_lock", int'(locked), 1);

        // Edge lands on the very cycle the count reaches the timeout
        pv_base = pv_cnt;
        tog_after(1000);
        check_val("coll_hp", last_hp, 1000);
        check_val("coll_pv", pv_cnt, pv_base + 1);
        check_val("coll_lost", int'(lost), 0);
        check_val("coll_locked", int'(locked), 0);
        check_val("coll_err", int'(err_cnt), 2);

        // Build err_cnt up to 3 and relock
        for (int i = 0; i < 4; i++) tog_after(51);
        check_val("pre3_locked", int'(locked), 1);
        tog_after(54);
        check_val("err3", int'(err_cnt), 3);
        for (int i = 0; i < 4; i++) tog_after(51);
        check_val("pre_rst_locked", int'(locked), 1);
        check_val("pre_rst_err", int'(err_cnt), 3);

        // Asynchronous mid-operation reset
        #3;
        rst_n  = 1'b0;
        clk_in = 1'b0;
        #1;
        check_val("mid_rst_locked", int'(locked), 0);
        check_val("mid_rst_err", int'(err_cnt), 0);
        check_val("mid_rst_hp", int'(half_period), 0);
        #9;
        rst_n = 1'b1;
        @(posedge clock); #1;
        pv_base = pv_cnt;
        tog_now();
        check_val("mid_rst_first_edge", pv_cnt, pv_base);
        for (int i = 0; i < 3; i++) tog_after(51);
        check_val("mid_rst_relock_3", int'(locked), 0);
        tog_after(51);
        check_val("mid_rst_relock_4", int'(locked), 1);
        check_val("mid_rst_err_after", int'(err_cnt), 0);
        check_val("mid_rst_hp_after", last_hp, 51);

        // Global properties
        check_val("pulses_never_both", both_cnt, 0);
        check_val("pulse_count", pulse_cnt, exp_pulses);
        check_val("reset_quiet_all", rst_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
- Receive-side companion to the board clock divider. Samples a slow, asynchronous clock (or strobe) into the fast `clock` domain.
- Detects its edges and emits single-cycle rise/fall strobes.
- Measures each half-period in fast cycles and reports lock, loss and error status.
- Sits between divided-clock producers (or external slow clocks) and logic in the fast domain that needs clock-enable strobes instead of a derived clock.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth on clk_in; legal range is 2..4.
- CNT_W, 16: width of the half-period counter and the half_period output.
- EXPECT_HALF, 51: nominal half-period in fast cycles.
- TOL, 2: allowed deviation; a measurement is good when EXPECT_HALF-TOL <= m <= EXPECT_HALF+TOL.
- LOCK_COUNT, 4: consecutive good measurements required to lock.
- TIMEOUT, 1000: fast cycles without an edge before loss is declared. Must be > EXPECT_HALF+TOL and < 2^CNT_W.

Ports:
- clock  in  1  fast system clock
- rst_n  in  1  asynchronous, active-low reset
- clk_in  in  1  monitored slow clock, asynchronous to clock
- rise_pulse  out  1  one-cycle strobe per detected rising edge
- fall_pulse  out  1  one-cycle strobe per detected falling edge
- half_period  out  CNT_W  last valid half-period measurement
- period_valid  out  1  one-cycle strobe when half_period updates
- locked  out  1  high in LOCKED state
- lost  out  1  high in LOST state
- err_cnt  out  8  saturating count of out-of-tolerance measurements while locked

Behaviour:
- Clocking and reset: one clock domain, `clock`. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - All synchroniser flops and the previous-sample flop are 0.
  - rise_pulse, fall_pulse, period_valid, locked and lost are 0.
  - half_period, err_cnt, the counter and the good-run counter are 0.
  - State is IDLE.
- Synchronisation:
  - clk_in passes through SYNC_STAGES flops, giving s. A further flop holds s_d.
  - Rise is detected when s=1 and s_d=0; fall when s=0 and s_d=1.
  - Pulses are registered and appear SYNC_STAGES+1 cycles after clk_in changes (3 cycles at the default).
  - An edge means any rise or fall.
- Counter cnt:
  - On an edge cycle, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 2^CNT_W-1.
  - With edges detected at cycles t and t+k, the measurement m is k.
- States:
  - IDLE: the first edge goes to ACQUIRE. No measurement is taken and the good-run counter is cleared.
  - ACQUIRE: on each edge, take measurement m=cnt.
    - half_period <= m and period_valid=1 for one cycle.
    - If m is good, the good-run counter increments. Reaching LOCK_COUNT moves to LOCKED.
    - If m is bad, the good-run counter is cleared.
  - LOCKED: on each edge, take a measurement as above.
    - A good measurement stays LOCKED.
    - A bad measurement increments err_cnt (saturating at 255), clears the good-run counter and moves to ACQUIRE.
  - Timeout: in ACQUIRE or LOCKED, cnt reaching TIMEOUT with no edge that cycle moves to LOST.
  - LOST: the good-run counter is cleared and no measurement is taken. The next edge goes to ACQUIRE without a measurement, because the saturated count is discarded.
- Flag timing: locked and lost are registered from the next state, so they change on the same edge that enters or leaves the state.
- Simultaneous events:
  - An edge in the same cycle cnt reaches TIMEOUT: the edge wins and is measured normally (m=TIMEOUT, which is out of tolerance).
  - rise_pulse and fall_pulse are never high together.
- Reset mid-operation: everything returns to the reset values immediately. err_cnt is cleared.
- Edge pulses: generated in every state, including IDLE and LOST.

Decomposition:
- Shared package (clk_pkg): the state encoding (IDLE=2'd0, ACQUIRE=2'd1, LOCKED=2'd2, LOST=2'd3) and default constants for EXPECT_HALF, TOL and TIMEOUT.
- One sub-module: sync_edge, parameterised by SYNC_STAGES. It contains the synchroniser chain plus edge detection and outputs s, rise and fall. The tracking FSM and counters stay in clk_monitor.

Test Plan:
- Reset: hold rst_n=0 while clk_in toggles. All outputs stay 0 and no pulses appear. Release reset and the state is IDLE.
- Nominal lock: drive clk_in with a 51-cycle half-period (102-cycle period).
  - The first rise_pulse appears 3 cycles after the first clk_in rise.
  - Every subsequent period_valid shows half_period=51.
  - locked=1 on the 4th measured edge; err_cnt stays 0.
- Tolerance boundaries: once locked, apply half-periods of 49 and 53. Both stay locked.
  - A half-period of 54 gives half_period=54, err_cnt=1, locked=0 (ACQUIRE).
  - Four further 51s restore locked=1.
- Timeout: once locked, hold clk_in static.
  - lost=1 exactly when cnt reaches 1000 (1000 cycles after the last detected edge).
  - The next edge gives lost=0, state ACQUIRE, and no period_valid pulse.
- Edge/timeout collision: place an edge detection exactly at cnt=TIMEOUT. The edge is measured (half_period=1000, period_valid=1), the state does not enter LOST, and err_cnt increments if previously locked.
- Mid-operation reset: pulse rst_n low for 1 cycle asynchronously while locked with err_cnt=3.
  - Outputs clear immediately and err_cnt=0.
  - Relock occurs after 4 good half-periods.
